// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and sizing helpers for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } ser_state_e;

  localparam int BYTE_W_DEFAULT = 8;

  function automatic int lanes_of(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Counter width for a count of n items, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from a sync_fifo read port and streams them out LSB byte first,
// framing every WORDS_PER_PKT words into a packet marked by out_last.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int BYTE_W        = BYTE_W_DEFAULT,
  parameter int WORDS_PER_PKT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_err,
  output logic              fifo_rd_en,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int LANES = lanes_of(DATA_W, BYTE_W);
  localparam int BCW   = cnt_width(LANES);
  localparam int WCW   = cnt_width(WORDS_PER_PKT);
  localparam logic [BCW-1:0] LAST_LANE = BCW'(LANES - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_PKT - 1);

  ser_state_e        state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [BCW-1:0]    byte_cnt_reg;
  logic [WCW-1:0]    word_cnt_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              err_reg;

  logic           lane_last;
  logic           word_last;
  logic [BCW-1:0] byte_cnt_next;

  assign lane_last     = (byte_cnt_reg == LAST_LANE);
  assign word_last     = (word_cnt_reg == LAST_WORD);
  assign byte_cnt_next = byte_cnt_reg + 1'b1;

  // Pop from IDLE, or prefetch when the last lane of a word is accepted.
  // Held off during rst so a reset never consumes a word.
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((state_reg == IDLE) ||
                       ((state_reg == SEND) && out_ready && lane_last));

  assign out_data  = shift_reg[BYTE_W-1:0];
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      byte_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (fifo_rd_err) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          shift_reg     <= fifo_rd_data;
          byte_cnt_reg  <= '0;
          out_valid_reg <= 1'b1;
          out_last_reg  <= (LANES == 1) && word_last;
          state_reg     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (!lane_last) begin
              shift_reg    <= shift_reg >> BYTE_W;
              byte_cnt_reg <= byte_cnt_next;
              out_last_reg <= (byte_cnt_next == LAST_LANE) && word_last;
            end else begin
              // word_cnt survives IDLE so a packet stalled on empty resumes framing
              word_cnt_reg  <= word_last ? '0 : word_cnt_reg + 1'b1;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              state_reg     <= fifo_empty ? IDLE : LOAD;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer fed by a behavioural sync FIFO.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rst;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_err;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int bad_pop = 0;

  logic        push_en;
  logic [31:0] push_data;
  logic        force_err;

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];
  int         pop_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_word_serializer #(.DATA_W(32), .BYTE_W(8), .WORDS_PER_PKT(4)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_err(fifo_rd_err),
    .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err(err)
  );

  // Upstream FIFO: 16 deep, registered read data one cycle after a pop.
  logic [31:0] fifo_mem [0:15];
  logic [3:0]  wp, rp;
  logic [4:0]  fcount;
  logic        rd_err_q;
  logic        do_pop;
  assign fifo_empty  = (fcount == 5'd0);
  assign do_pop      = fifo_rd_en && !fifo_empty;
  assign fifo_rd_err = rd_err_q | force_err;

  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0; rp <= '0; fcount <= '0; rd_err_q <= 1'b0; fifo_rd_data <= '0;
    end else begin
      rd_err_q <= fifo_rd_en && fifo_empty;
      if (push_en) begin
        fifo_mem[wp] <= push_data;
        wp <= wp + 4'd1;
      end
      if (do_pop) begin
        fifo_rd_data <= fifo_mem[rp];
        rp <= rp + 4'd1;
      end
      fcount <= fcount + {4'd0, push_en} - {4'd0, do_pop};
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      rx_cyc.push_back(cyc);
    end
    if (fifo_rd_en) begin
      pop_cyc.push_back(cyc);
      if (fifo_empty) bad_pop <= bad_pop + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rx();
    rx_data.delete(); rx_last.delete(); rx_cyc.delete(); pop_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_rx();
  endtask

  task automatic push(input logic [31:0] w);
    @(posedge clk); #1 push_en = 1'b1; push_data = w;
    @(posedge clk); #1 push_en = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int i = 0; i < 300 && rx_data.size() < n; i++) @(negedge clk);
    check(tag, 64'(rx_data.size()), 64'(n));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check(tag, {63'd0, out_valid}, 64'd1);
  endtask

  function automatic logic [31:0] last_mask(input int n);
    logic [31:0] m = '0;
    for (int i = 0; i < n && i < rx_last.size(); i++) m[i] = rx_last[i];
    return m;
  endfunction

  logic [31:0] word_v;
  int busy_seen;

  initial begin
    rst = 1'b1; fifo_rst = 1'b1; push_en = 1'b0; push_data = '0;
    force_err = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; fifo_rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", {56'd0, out_data}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);

    // single word
    clear_rx();
    out_ready = 1'b1;
    push(32'h44332211);
    wait_bytes("single_count", 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_byte%0d", i), {56'd0, rx_data[i]}, 64'(8'h11 * (i + 1)));
      check($sformatf("single_cyc%0d", i), 64'(rx_cyc[i] - rx_cyc[0]), 64'(i));
    end
    check("single_latency", 64'(rx_cyc[0] - pop_cyc[0]), 64'd2);
    check("single_last", {32'd0, last_mask(4)}, 64'd0);

    // streaming 8 words
    do_reset();
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) word_v[b*8 +: 8] = 8'(4 * w + b);
      push(word_v);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_bytes("stream_count", 32);
    for (int i = 0; i < 32; i++)
      check($sformatf("stream_byte%0d", i), {56'd0, rx_data[i]}, 64'(i));
    check("stream_last", {32'd0, last_mask(32)}, 64'h8000_8000);
    check("stream_span", 64'(rx_cyc[31] - rx_cyc[0]), 64'd38);
    check("stream_bubble", 64'(rx_cyc[4] - rx_cyc[3]), 64'd2);

    // backpressure on byte 22 and on the last byte with a word waiting
    do_reset();
    out_ready = 1'b0;
    push(32'h44332211);
    push(32'h88776655);
    wait_valid("bp_valid");
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold22_%0d", i), {56'd0, out_data}, 64'h22);
      check($sformatf("bp_nopop22_%0d", i), {63'd0, fifo_rd_en}, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold44_%0d", i), {56'd0, out_data}, 64'h44);
      check($sformatf("bp_nopop44_%0d", i), {63'd0, fifo_rd_en}, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_bytes("bp_count", 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_byte%0d", i), {56'd0, rx_data[i]}, 64'(8'h11 * (i + 1)));
    check("bp_pops", 64'(pop_cyc.size()), 64'd2);

    // underflow stall between words 2 and 3
    do_reset();
    out_ready = 1'b1;
    push(32'h14131211);
    push(32'h24232221);
    wait_bytes("stall_count_a", 8);
    @(posedge clk);
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("stall_busy", 64'(busy_seen), 64'd0);
    push(32'h34333231);
    push(32'h44332211);
    wait_bytes("stall_count_b", 16);
    check("stall_last", {32'd0, last_mask(16)}, 64'h8000);
    check("stall_byte15", {56'd0, rx_data[15]}, 64'h44);

    // reset after byte 22 of word A
    do_reset();
    out_ready = 1'b0;
    push(32'h44332211);
    wait_valid("mid_valid");
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_valid0", {63'd0, out_valid}, 64'd0);
    check("mid_data0", {56'd0, out_data}, 64'd0);
    check("mid_last0", {63'd0, out_last}, 64'd0);
    check("mid_busy0", {63'd0, busy}, 64'd0);
    check("mid_rd_en0", {63'd0, fifo_rd_en}, 64'd0);
    clear_rx();
    out_ready = 1'b1;
    push(32'hDDCCBBAA);
    push(32'h01020304);
    push(32'h05060708);
    push(32'h090A0B0C);
    wait_bytes("mid_count", 16);
    check("mid_byte0", {56'd0, rx_data[0]}, 64'hAA);
    check("mid_byte1", {56'd0, rx_data[1]}, 64'hBB);
    check("mid_byte2", {56'd0, rx_data[2]}, 64'hCC);
    check("mid_byte3", {56'd0, rx_data[3]}, 64'hDD);
    check("mid_last", {32'd0, last_mask(16)}, 64'h8000);

    // error latch
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1 force_err = 1'b1;
    @(posedge clk); #1 force_err = 1'b0;
    @(negedge clk);
    check("err_set", {63'd0, err}, 64'd1);
    push(32'hA3A2A1A0);
    wait_bytes("err_count", 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("err_byte%0d", i), {56'd0, rx_data[i]}, 64'(8'hA0 + i));
    repeat (5) @(negedge clk);
    check("err_sticky", {63'd0, err}, 64'd1);
    do_reset();
    @(negedge clk);
    check("err_clear", {63'd0, err}, 64'd0);

    check("no_pop_when_empty", 64'(bad_pop), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Downstream read stage for `sync_fifo`. Pops DATA_W-bit words from the FIFO read port and emits them as BYTE_W-bit symbols on a valid/ready stream, least-significant byte first. Symbols are framed into packets of WORDS_PER_PKT words, with `out_last` marking the final byte of each packet. It sits directly on the FIFO's read side and is the sole driver of `fifo_rd_en`.

## Interface
- DATA_W, 32, FIFO word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8, output symbol width.
- WORDS_PER_PKT, 4, words per packet; ≥1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after a pop.
- fifo_rd_err  in  1  FIFO read-underflow pulse.
- fifo_rd_en  out  1  pop request; combinational from state and `fifo_empty`.
- out_data  out  BYTE_W  current symbol.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  final byte of packet; qualified by `out_valid`.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set by `fifo_rd_err`, cleared only by `rst`.

## Operation
- LANES = DATA_W/BYTE_W; byte counter width is clog2(LANES), minimum 1. Word counter width is clog2(WORDS_PER_PKT), minimum 1.
- **IDLE**
  - `fifo_rd_en = !fifo_empty`.
  - If not empty, go to LOAD.
- **LOAD**
  - `fifo_rd_en = 0`.
  - Capture `fifo_rd_data` into the shift register and clear the byte counter.
  - Go to SEND.
- **SEND**
  - `out_valid = 1`; `out_data = shift[BYTE_W-1:0]`.
  - `out_last = (byte_cnt == LANES-1) && (word_cnt == WORDS_PER_PKT-1)`.
  - On `out_ready`, if not the last lane: shift right by BYTE_W and increment `byte_cnt`.
  - On `out_ready` at the last lane: word is done. `word_cnt` increments, wrapping to 0 after WORDS_PER_PKT-1. Then:
    - if `!fifo_empty`, assert `fifo_rd_en` this cycle and go to LOAD (prefetch);
    - otherwise go to IDLE.
- `fifo_rd_en` is never asserted while `fifo_empty` is high, so `fifo_rd_err` should never fire. If it does, `err` latches.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_last` and all state hold unchanged.
- A packet may stall mid-way on FIFO empty. `word_cnt` is retained across IDLE, so framing continues where it left off.

## Timing
- Reset values (after a `rst` edge): state IDLE, `fifo_rd_en` 0 (combinationally, as state is IDLE only once FIFO non-empty is evaluated; with FIFO empty it is 0), `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `err` 0, both counters 0, shift register 0.
- Latency: pop in cycle N (IDLE, non-empty) → data captured at end of N+1 → first `out_valid` in N+2.
- With `out_ready` held high and the FIFO non-empty, throughput is LANES bytes per LANES+1 cycles; the LOAD cycle is the only bubble.
- Simultaneous last-byte accept and FIFO non-empty: the pop and the transition to LOAD occur in the same cycle. No extra IDLE cycle.
- `out_ready` low on the last byte: no pop is issued until that byte is accepted.
- `rst` mid-word or mid-packet:
  - The partially sent word is discarded and not re-read.
  - `word_cnt` returns to 0; the next byte starts a fresh packet.
  - `rst` dominates all other inputs in the same cycle.
- `out_valid` deasserts only in the cycle after the last byte of a word is accepted.

## Structure
- Shared package `fifo_ser_pkg`:
  - state enum: IDLE, LOAD, SEND;
  - default BYTE_W;
  - the LANES computation function.
- Single module. No sub-module is warranted.
- The bench instantiates `sync_fifo` upstream, wired port-for-port on `fifo_*`.

## Test plan
- **Single word:** write 32'h44332211, `out_ready`=1.
  - Bytes 11, 22, 33, 44 appear on consecutive cycles, first at pop+2.
  - `out_last`=0 throughout (WORDS_PER_PKT=4).
- **Streaming:** 8 words preloaded, `out_ready`=1.
  - 32 bytes in 40 cycles; one bubble per word.
  - `out_last` high on bytes 15 and 31 only.
  - `fifo_rd_en` never high with `fifo_empty` high.
- **Backpressure:** `out_ready` low for 3 cycles while byte 22 is presented.
  - `out_data` holds 22 and no pop occurs.
  - Sequence resumes intact.
- **Underflow stall:** 2 words, a 10-cycle gap, then 2 more words.
  - Framing continues; `out_last` lands on the byte 44 of the 4th word.
  - `busy` is 0 during the gap.
- **Mid-word reset:** pulse `rst` after byte 22 of word A; FIFO then holds word B = 32'hDDCCBBAA.
  - All outputs are at reset values the cycle after.
  - Next bytes are AA, BB, CC, DD, and `word_cnt` restarts at 0.
- **Error latch:** force `fifo_rd_err` high for 1 cycle.
  - `err`=1 and stays high until `rst`.
  - Data path is unaffected.
